// File: rtl/tlp_mux.sv
// ---------------------------------------------------------------------------
// tlp_mux
//
// Merges the read-completion TLP stream and the write TLP stream into a single
// outgoing TLP stream toward the PCIe transaction layer. Sources are granted
// whole packets at a time, alternating round-robin on ties, and every accepted
// beat passes through one output register (one cycle of latency, no skid).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   r_in_data/hdr/sop/eop      read-source beat (payload, header, framing)
//   r_in_valid / r_in_ready    read-source handshake
//   w_in_data/hdr/sop/eop      write-source beat (payload, header, framing)
//   w_in_valid / w_in_ready    write-source handshake
//   out_data/hdr/sop/eop       merged beat
//   out_valid / out_ready      merged-stream handshake
//   enable                     permits new packet grants
//   err_drop                   one-cycle pulse after a stray beat is discarded
// ---------------------------------------------------------------------------
module tlp_mux #(
  parameter int PORTS        = 2,
  parameter int DOUBLE_WORD  = 32,
  parameter int HEADER_SIZE  = 4 * DOUBLE_WORD,
  parameter int PAYLOAD_SIZE = 8 * DOUBLE_WORD
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic [PAYLOAD_SIZE-1:0] r_in_data,
  input  logic [HEADER_SIZE-1:0]  r_in_hdr,
  input  logic                    r_in_sop,
  input  logic                    r_in_eop,
  input  logic                    r_in_valid,
  output logic                    r_in_ready,

  input  logic [PAYLOAD_SIZE-1:0] w_in_data,
  input  logic [HEADER_SIZE-1:0]  w_in_hdr,
  input  logic                    w_in_sop,
  input  logic                    w_in_eop,
  input  logic                    w_in_valid,
  output logic                    w_in_ready,

  output logic [PAYLOAD_SIZE-1:0] out_data,
  output logic [HEADER_SIZE-1:0]  out_hdr,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic                    out_valid,
  input  logic                    out_ready,

  input  logic                    enable,
  output logic                    err_drop
);

  localparam int SRC_BITS = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [SRC_BITS-1:0] SRC_RD = '0;
  localparam logic [SRC_BITS-1:0] SRC_WR = SRC_BITS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_R = 2'd1,
    GNT_W = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [SRC_BITS-1:0] last;
  logic [SRC_BITS-1:0] last_next;

  logic req_r;
  logic req_w;
  logic out_free;
  logic r_accept;
  logic w_accept;
  logic load_r;
  logic load_w;
  logic drop_any;

  // A packet request needs a valid start-of-packet beat and permission to grant.
  assign req_r    = r_in_valid & r_in_sop & enable;
  assign req_w    = w_in_valid & w_in_sop & enable;
  // The output register can take a beat when empty or being drained this cycle.
  assign out_free = !out_valid | out_ready;

  // State register and round-robin pointer. The pointer resets to the write
  // source so that the read source wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= SRC_WR;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold the grant until the granted
  // source's eop beat is accepted, then return to IDLE for one bubble cycle.
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        if (req_r && req_w) begin
          state_next = (last == SRC_WR) ? GNT_R : GNT_W;
        end else if (req_r) begin
          state_next = GNT_R;
        end else if (req_w) begin
          state_next = GNT_W;
        end
      end
      GNT_R: begin
        if (r_accept && r_in_eop) begin
          state_next = IDLE;
          last_next  = SRC_RD;
        end
      end
      GNT_W: begin
        if (w_accept && w_in_eop) begin
          state_next = IDLE;
          last_next  = SRC_WR;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode: in IDLE only stray (non-sop) beats are accepted so they can
  // be discarded; in a grant state the granted source follows the output
  // register's free condition, giving same-cycle backpressure.
  always_comb begin
    r_in_ready = 1'b0;
    w_in_ready = 1'b0;
    case (state)
      IDLE: begin
        r_in_ready = r_in_valid & !r_in_sop;
        w_in_ready = w_in_valid & !w_in_sop;
      end
      GNT_R: begin
        r_in_ready = out_free;
      end
      GNT_W: begin
        w_in_ready = out_free;
      end
      default: begin
        r_in_ready = 1'b0;
        w_in_ready = 1'b0;
      end
    endcase
    r_accept = r_in_valid & r_in_ready;
    w_accept = w_in_valid & w_in_ready;
    load_r   = r_accept & (state == GNT_R);
    load_w   = w_accept & (state == GNT_W);
    // Simultaneous strays from both sources collapse into one pulse.
    drop_any = (state == IDLE) & (r_accept | w_accept);
  end

  // Output register and error pulse. Data fields only change on a load, so
  // they hold steady while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_hdr   <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_valid <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      err_drop <= drop_any;
      if (load_r) begin
        out_data  <= r_in_data;
        out_hdr   <= r_in_hdr;
        out_sop   <= r_in_sop;
        out_eop   <= r_in_eop;
        out_valid <= 1'b1;
      end else if (load_w) begin
        out_data  <= w_in_data;
        out_hdr   <= w_in_hdr;
        out_sop   <= w_in_sop;
        out_eop   <= w_in_eop;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tlp_mux.sv
// ---------------------------------------------------------------------------
// tb_tlp_mux
//
// Directed bench for tlp_mux. Expected output beats are queued as each test's
// stimulus is set up, in the order the arbitration should emit them; a monitor
// pops one entry per accepted output beat and compares it. Cycle-specific
// handshake, timing and error-pulse behaviour is checked inline.
// ---------------------------------------------------------------------------
module tb_tlp_mux;

  localparam int DW  = 32;
  localparam int HW  = 4 * DW;
  localparam int PW  = 8 * DW;

  typedef struct packed {
    logic [PW-1:0] data;
    logic [HW-1:0] hdr;
    logic          sop;
    logic          eop;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic [PW-1:0] r_in_data;
  logic [HW-1:0] r_in_hdr;
  logic          r_in_sop;
  logic          r_in_eop;
  logic          r_in_valid;
  logic          r_in_ready;
  logic [PW-1:0] w_in_data;
  logic [HW-1:0] w_in_hdr;
  logic          w_in_sop;
  logic          w_in_eop;
  logic          w_in_valid;
  logic          w_in_ready;
  logic [PW-1:0] out_data;
  logic [HW-1:0] out_hdr;
  logic          out_sop;
  logic          out_eop;
  logic          out_valid;
  logic          out_ready;
  logic          enable;
  logic          err_drop;

  int    checks;
  int    errors;
  beat_t sb[$];
  beat_t mon_exp;

  tlp_mux #(
    .PORTS(2),
    .DOUBLE_WORD(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .r_in_data(r_in_data),
    .r_in_hdr(r_in_hdr),
    .r_in_sop(r_in_sop),
    .r_in_eop(r_in_eop),
    .r_in_valid(r_in_valid),
    .r_in_ready(r_in_ready),
    .w_in_data(w_in_data),
    .w_in_hdr(w_in_hdr),
    .w_in_sop(w_in_sop),
    .w_in_eop(w_in_eop),
    .w_in_valid(w_in_valid),
    .w_in_ready(w_in_ready),
    .out_data(out_data),
    .out_hdr(out_hdr),
    .out_sop(out_sop),
    .out_eop(out_eop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .enable(enable),
    .err_drop(err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat contents derived from a 32-bit id so every beat is distinct.
  function automatic logic [PW-1:0] mkData(input logic [31:0] id);
    return {8{id}};
  endfunction

  function automatic logic [HW-1:0] mkHdr(input logic [31:0] id);
    return {4{id ^ 32'h5A5A_0000}};
  endfunction

  // Drive one source (is_w selects the write source).
  task automatic applyStimulus(input bit is_w, input logic v, input logic sop,
                               input logic eop, input logic [31:0] id);
    if (is_w) begin
      w_in_valid = v;
      w_in_sop   = sop;
      w_in_eop   = eop;
      w_in_data  = mkData(id);
      w_in_hdr   = mkHdr(id);
    end else begin
      r_in_valid = v;
      r_in_sop   = sop;
      r_in_eop   = eop;
      r_in_data  = mkData(id);
      r_in_hdr   = mkHdr(id);
    end
  endtask

  task automatic pushExp(input logic [31:0] id, input logic sop, input logic eop);
    beat_t b;
    b.data = mkData(id);
    b.hdr  = mkHdr(id);
    b.sop  = sop;
    b.eop  = eop;
    sb.push_back(b);
  endtask

  task automatic checkOutput(input string tag, input logic [PW-1:0] observed,
                             input logic [PW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the rising edge; checks happen on the falling edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic atNeg();
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) nextCycle();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idleCycles(2);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: each accepted output beat must match the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_beat: observed data %0h expected no beat", out_data);
      end
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        checks++;
        assert ({out_data, out_hdr, out_sop, out_eop} === mon_exp) else begin
          errors++;
          $error("[TB] FAIL beat: observed %0h/%0h sop=%0b eop=%0b expected %0h/%0h sop=%0b eop=%0b",
                 out_data, out_hdr, out_sop, out_eop,
                 mon_exp.data, mon_exp.hdr, mon_exp.sop, mon_exp.eop);
        end
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    out_ready = 1'b1;
    enable    = 1'b1;
    rst_n     = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;

    // Reset values while reset is held.
    atNeg();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_hdr", out_hdr, 0);
    checkOutput("rst_out_sop_eop", {out_sop, out_eop}, 0);
    checkOutput("rst_ready", {r_in_ready, w_in_ready}, 0);
    checkOutput("rst_err_drop", err_drop, 0);
    nextCycle();
    rst_n = 1'b1;
    idleCycles(2);

    // Single read packet A1..A3 with the downstream always ready.
    $display("[TB] single source read packet");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'hA1);
    pushExp(32'hA1, 1'b1, 1'b0);
    pushExp(32'hA2, 1'b0, 1'b0);
    pushExp(32'hA3, 1'b0, 1'b1);
    atNeg();
    checkOutput("t1_c0_r_ready", r_in_ready, 0);
    checkOutput("t1_c0_w_ready", w_in_ready, 0);
    nextCycle();
    atNeg();
    checkOutput("t1_c1_r_ready", r_in_ready, 1);
    checkOutput("t1_c1_out_valid", out_valid, 0);
    checkOutput("t1_c1_w_ready", w_in_ready, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'hA2);
    atNeg();
    checkOutput("t1_c2_out_valid", out_valid, 1);
    checkOutput("t1_c2_w_ready", w_in_ready, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hA3);
    atNeg();
    checkOutput("t1_c3_out_valid", out_valid, 1);
    checkOutput("t1_c3_w_ready", w_in_ready, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    atNeg();
    checkOutput("t1_c4_out_valid", out_valid, 1);
    checkOutput("t1_c4_w_ready", w_in_ready, 0);
    nextCycle();
    atNeg();
    checkOutput("t1_c5_out_valid", out_valid, 0);
    idleCycles(3);
    checkOutput("t1_sb_empty", PW'(sb.size()), 0);

    // Tie right after reset: read wins, write follows after one bubble, and
    // the next tie goes back to read.
    $display("[TB] tie after reset");
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hB0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hC0);
    pushExp(32'hB0, 1'b1, 1'b1);
    pushExp(32'hC0, 1'b1, 1'b1);
    atNeg();
    checkOutput("t2_c0_ready", {r_in_ready, w_in_ready}, 0);
    nextCycle();
    atNeg();
    checkOutput("t2_c1_r_ready", r_in_ready, 1);
    checkOutput("t2_c1_w_ready", w_in_ready, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    atNeg();
    checkOutput("t2_c2_out_valid", out_valid, 1);
    checkOutput("t2_c2_w_ready", w_in_ready, 0);
    nextCycle();
    atNeg();
    checkOutput("t2_c3_w_ready", w_in_ready, 1);
    checkOutput("t2_c3_bubble", out_valid, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hB1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hC1);
    pushExp(32'hB1, 1'b1, 1'b1);
    pushExp(32'hC1, 1'b1, 1'b1);
    atNeg();
    checkOutput("t2_c4_out_valid", out_valid, 1);
    checkOutput("t2_c4_ready", {r_in_ready, w_in_ready}, 0);
    nextCycle();
    atNeg();
    checkOutput("t2_c5_r_ready", r_in_ready, 1);
    checkOutput("t2_c5_w_ready", w_in_ready, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    atNeg();
    checkOutput("t2_c6_w_ready", w_in_ready, 0);
    nextCycle();
    atNeg();
    checkOutput("t2_c7_w_ready", w_in_ready, 1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idleCycles(3);
    checkOutput("t2_sb_empty", PW'(sb.size()), 0);

    // Four-beat write packet with the downstream stalled for three cycles.
    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'hD1);
    pushExp(32'hD1, 1'b1, 1'b0);
    pushExp(32'hD2, 1'b0, 1'b0);
    pushExp(32'hD3, 1'b0, 1'b0);
    pushExp(32'hD4, 1'b0, 1'b1);
    atNeg();
    checkOutput("t3_c0_w_ready", w_in_ready, 0);
    nextCycle();
    atNeg();
    checkOutput("t3_c1_w_ready", w_in_ready, 1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'hD2);
    atNeg();
    checkOutput("t3_c2_w_ready", w_in_ready, 1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'hD3);
    out_ready = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      atNeg();
      checkOutput($sformatf("t3_c%0d_w_ready", c), w_in_ready, 0);
      checkOutput($sformatf("t3_c%0d_hold_data", c), out_data, mkData(32'hD2));
      checkOutput($sformatf("t3_c%0d_out_valid", c), out_valid, 1);
      nextCycle();
    end
    out_ready = 1'b1;
    atNeg();
    checkOutput("t3_c6_w_ready", w_in_ready, 1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hD4);
    atNeg();
    checkOutput("t3_c7_w_ready", w_in_ready, 1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    atNeg();
    checkOutput("t3_c8_last_data", out_data, mkData(32'hD4));
    idleCycles(3);
    checkOutput("t3_sb_empty", PW'(sb.size()), 0);

    // Write requests while a four-beat read packet is in flight.
    $display("[TB] atomicity");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'hE1);
    pushExp(32'hE1, 1'b1, 1'b0);
    pushExp(32'hE2, 1'b0, 1'b0);
    pushExp(32'hE3, 1'b0, 1'b0);
    pushExp(32'hE4, 1'b0, 1'b1);
    pushExp(32'hF0, 1'b1, 1'b1);
    atNeg();
    checkOutput("t4_c0_r_ready", r_in_ready, 0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hF0);
    atNeg();
    checkOutput("t4_c1_r_ready", r_in_ready, 1);
    checkOutput("t4_c1_w_ready", w_in_ready, 0);
    for (int c = 2; c <= 4; c++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, (c == 4), 32'hE0 + 32'(c));
      atNeg();
      checkOutput($sformatf("t4_c%0d_r_ready", c), r_in_ready, 1);
      checkOutput($sformatf("t4_c%0d_w_ready", c), w_in_ready, 0);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    atNeg();
    checkOutput("t4_c5_w_ready", w_in_ready, 0);
    nextCycle();
    atNeg();
    checkOutput("t4_c6_w_ready", w_in_ready, 1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idleCycles(3);
    checkOutput("t4_sb_empty", PW'(sb.size()), 0);

    // Grants held off by enable; dropping enable mid-packet does not stall it.
    $display("[TB] enable gating");
    enable = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h71);
    pushExp(32'h71, 1'b1, 1'b0);
    pushExp(32'h72, 1'b0, 1'b1);
    for (int c = 0; c <= 2; c++) begin
      atNeg();
      checkOutput($sformatf("t5_c%0d_ready", c), {r_in_ready, w_in_ready}, 0);
      checkOutput($sformatf("t5_c%0d_out_valid", c), out_valid, 0);
      nextCycle();
    end
    enable = 1'b1;
    atNeg();
    checkOutput("t5_c3_r_ready", r_in_ready, 0);
    nextCycle();
    enable = 1'b0;
    atNeg();
    checkOutput("t5_c4_r_ready", r_in_ready, 1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h72);
    atNeg();
    checkOutput("t5_c5_r_ready", r_in_ready, 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    atNeg();
    checkOutput("t5_c6_out_valid", out_valid, 1);
    enable = 1'b1;
    idleCycles(3);
    checkOutput("t5_sb_empty", PW'(sb.size()), 0);

    // Stray beat on the write source, then strays on both sources at once.
    $display("[TB] stray beats");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h99);
    atNeg();
    checkOutput("t6_w_ready", w_in_ready, 1);
    checkOutput("t6_c0_err_drop", err_drop, 0);
    checkOutput("t6_c0_out_valid", out_valid, 0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    atNeg();
    checkOutput("t6_c1_err_drop", err_drop, 1);
    checkOutput("t6_c1_out_valid", out_valid, 0);
    checkOutput("t6_c1_w_ready", w_in_ready, 0);
    nextCycle();
    atNeg();
    checkOutput("t6_c2_err_drop", err_drop, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h9A);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h9B);
    atNeg();
    checkOutput("t6_both_ready", {r_in_ready, w_in_ready}, 2'b11);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    atNeg();
    checkOutput("t6_both_err_drop", err_drop, 1);
    checkOutput("t6_both_out_valid", out_valid, 0);
    nextCycle();
    atNeg();
    checkOutput("t6_both_err_end", err_drop, 0);
    idleCycles(2);

    // Reset asserted after the first beat of a packet has been emitted.
    $display("[TB] reset mid-packet");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h61);
    nextCycle();
    atNeg();
    checkOutput("t7_r_ready", r_in_ready, 1);
    nextCycle();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    atNeg();
    checkOutput("t7_out_valid", out_valid, 0);
    checkOutput("t7_out_data", out_data, 0);
    checkOutput("t7_ready", {r_in_ready, w_in_ready}, 0);
    nextCycle();
    rst_n = 1'b1;
    idleCycles(3);
    checkOutput("t7_sb_empty", PW'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlp_mux.md
# tlp_mux

Transmit-side counterpart of the TLP demultiplexer: merges the read-completion TLP stream and the write TLP stream into one outgoing TLP stream toward the PCIe transaction layer. Arbitration is packet-atomic round-robin between the two sources. A registered output stage gives one cycle of latency. Sits between the AXI-side request/completion engines and the PCIe TX interface.

## Interface
- PORTS, 2, number of merged sources; fixed at 2 (read, write)
- DOUBLE_WORD, 32, DW width in bits
- HEADER_SIZE, 4*DOUBLE_WORD, TLP header width
- PAYLOAD_SIZE, 8*DOUBLE_WORD, payload beat width

Ports:
- clk  in  1  clock; everything is synchronous to its rising edge
- rst_n  in  1  reset; asynchronous and active-low
- r_in_data  in  PAYLOAD_SIZE  read-source payload beat
- r_in_hdr  in  HEADER_SIZE  read-source header; sampled with every beat
- r_in_sop / r_in_eop  in  1  read-source start / end of packet
- r_in_valid  in  1  read-source beat valid
- r_in_ready  out  1  read-source beat accepted
- w_in_data, w_in_hdr, w_in_sop, w_in_eop, w_in_valid, w_in_ready: same widths and meanings for the write source
- out_data  out  PAYLOAD_SIZE  merged payload
- out_hdr  out  HEADER_SIZE  merged header
- out_sop / out_eop  out  1  merged start / end of packet
- out_valid  out  1  merged beat valid
- out_ready  in  1  downstream accepts the beat
- enable  in  1  permits new grants
- err_drop  out  1  one-cycle pulse when a stray beat is discarded

## Operation
- FSM states: IDLE, GNT_R, GNT_W. Pointer `last` records the last granted source.
- IDLE:
  - req_r = r_in_valid & r_in_sop & enable; req_w is formed the same way.
  - One request → go to that grant state.
  - Both requests → grant the source other than `last`.
  - No request → stay in IDLE.
  - Both in_ready outputs are 0 for sourcing beats in IDLE.
- GNT_x:
  - x_in_ready = !out_valid | out_ready. The other source's ready is 0.
  - An accepted beat (x_in_valid & x_in_ready) loads the output register with data, hdr, sop and eop, and sets out_valid=1.
  - Accepting a beat with eop=1 → IDLE and last←x. A single-beat packet (sop=eop=1) counts.
- Output register: when out_valid & out_ready and no new beat loads, out_valid←0. Data fields hold their value while out_valid=1 and out_ready=0.
- Stray beat: in IDLE, a source with valid=1 and sop=0 is accepted and discarded. That source's in_ready=1 for the cycle, and err_drop pulses one cycle later. If both sources are stray in the same cycle, both are dropped and a single err_drop pulse is produced.
- A beat with sop=1 arriving mid-packet on the granted source is forwarded unchanged. No checking is done.
- enable=0 only blocks new grants. A packet already granted completes.
- Packets are never interleaved on the output. Header and payload are passed bit-exact.

## Timing
- Reset values: state=IDLE, last=W (so the read source wins the first tie), out_valid=0, out_data=0, out_hdr=0, out_sop=0, out_eop=0, r_in_ready=0, w_in_ready=0, err_drop=0.
- Arbitration takes one cycle: a request seen in IDLE at cycle N gives in_ready=1 at N+1. The first beat is accepted at N+1 and appears on the output at N+2.
- Beat latency is 1 cycle from input acceptance to out_valid.
- Steady-state throughput is one beat per cycle within a packet while out_ready=1.
- There is one bubble cycle (IDLE) between consecutive packets.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 the same cycle (combinational from out_ready). There is no skid buffer.
- Asserting rst_n low mid-packet aborts immediately to reset values. A partial packet already emitted is not completed.

## Test plan
- Single source: the read source sends a 3-beat packet with payloads A1, A2, A3 while out_ready=1. Required: grant at cycle 1; out_valid at cycles 2–4 carrying A1..A3; sop only on A1, eop only on A3; w_in_ready stays 0 throughout.
- Tie after reset: both sources present sop at cycle 0 with single-beat packets R0 and W0. Required: R0 is output first. W0 is output 2 cycles after R0 (one IDLE bubble). A following tie grants R again.
- Backpressure: out_ready=0 for cycles 3–5 during a 4-beat write packet. Required: out_data holds the same beat; w_in_ready=0 at cycles 3–5; all 4 beats arrive in order with none lost or duplicated.
- Atomicity: read packet of 4 beats in flight while the write source asserts valid+sop. Required: no write beat is accepted until the read eop is accepted; the write grant comes one cycle after.
- enable=0 with a pending request. Required: no grant and in_ready=0. Raising enable → grant on the next cycle. Dropping enable mid-packet → the packet still completes.
- Stray beat: w_in_valid=1 with sop=0 in IDLE. Required: w_in_ready=1 for one cycle, err_drop=1 on the following cycle, out_valid stays 0.
